// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the key schedule and the cipher datapath.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] p;

    always_comb begin
        // Addition chain for x^254; zero maps to zero as required.
        p = gf_mul(in_i, in_i);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        p = gf_mul(p, in_i);
        p = gf_mul(p, p);
        out_o = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                  ^ {p[3:0], p[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: the byte S-box applied independently to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w_i,
    output word_t w_o
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (w_i[8*b +: 8]),
            .out_o (w_o[8*b +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES key expansion for AES-128/192/256, streaming 128-bit round
// keys over a valid/ready handshake with backpressure.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_index,
    output logic             rk_last,
    output logic             done
);

    localparam int NR     = nr_of(NK);
    localparam int LAST_I = 4 * (NR + 1) - 1;

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_key_expander: NK must be 4, 6 or 8");
    end

    state_e           state_q;
    logic [32*NK-1:0] win_q;      // oldest word (w[i-NK]) in the top slot
    logic [5:0]       i_q;
    logic [2:0]       m_q;        // i mod NK
    logic [7:0]       rcon_q;
    logic [95:0]      buf_q;
    logic [1:0]       cnt_q;
    logic [3:0]       rnd_q;
    logic [127:0]     rk_data_q;
    logic             rk_valid_q, rk_last_q, busy_q, done_q;
    logic [3:0]       rk_index_q;

    word_t oldest, prev, sw_in, sw_out, t, word_d;
    logic  produce, accept;

    assign oldest = win_q[32*NK-1 -: 32];
    assign prev   = win_q[31:0];
    assign sw_in  = (m_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_sub_word u_sub_word (
        .w_i (sw_in),
        .w_o (sw_out)
    );

    always_comb begin
        t = prev;
        if (m_q == 3'd0)
            t = sw_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && m_q == 3'd4)
            t = sw_out;
        word_d = (i_q < 6'(NK)) ? oldest : (oldest ^ t);
    end

    // Hold generation while the 4th word has nowhere to go.
    assign produce = (state_q == GEN) && !(cnt_q == 2'd3 && rk_valid_q && !rk_ready);
    assign accept  = rk_valid_q && rk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            i_q        <= '0;
            m_q        <= '0;
            rcon_q     <= RCON_INIT;
            buf_q      <= '0;
            cnt_q      <= '0;
            rnd_q      <= '0;
            rk_data_q  <= '0;
            rk_valid_q <= 1'b0;
            rk_index_q <= '0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        win_q   <= key_in;
                        i_q     <= '0;
                        m_q     <= '0;
                        rcon_q  <= RCON_INIT;
                        cnt_q   <= '0;
                        rnd_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    if (produce) begin
                        win_q <= {win_q[32*NK-33:0], word_d};
                        i_q   <= i_q + 6'd1;
                        m_q   <= (m_q == 3'(NK - 1)) ? 3'd0 : m_q + 3'd1;
                        if (i_q >= 6'(NK) && m_q == 3'd0)
                            rcon_q <= xtime(rcon_q);
                        if (cnt_q == 2'd3) begin
                            rk_data_q  <= {buf_q, word_d};
                            rk_valid_q <= 1'b1;
                            rk_index_q <= rnd_q;
                            rk_last_q  <= (rnd_q == 4'(NR));
                            rnd_q      <= rnd_q + 4'd1;
                            cnt_q      <= 2'd0;
                        end else begin
                            buf_q <= {buf_q[63:0], word_d};
                            cnt_q <= cnt_q + 2'd1;
                        end
                        if (i_q == 6'(LAST_I))
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_index = rk_index_q;
    assign rk_last  = rk_last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: one instance per key size, FIPS-197 vectors.
module tb_aes_key_expander;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   idx;
        logic         last;
        logic         chk;
    } exp_t;

    localparam logic [127:0] K128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    localparam logic [255:0] KEY_A   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_B   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [255:0] key = '0;
    int           sel = 0;
    logic         rnd_mode = 1'b0;
    int           edge_cnt = 0;
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    exp_t         sb_q[$];

    logic         b4, v4, l4, dn4, b6, v6, l6, dn6, b8, v8, l8, dn8;
    logic [127:0] d4, d6, d8;
    logic [3:0]   i4, i6, i8;
    logic         m_busy, m_valid, m_last, m_done;
    logic [127:0] m_data;
    logic [3:0]   m_idx;
    logic         st4, st6, st8;

    assign st4 = start && (sel == 0);
    assign st6 = start && (sel == 1);
    assign st8 = start && (sel == 2);

    aes_key_expander #(.NK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .key_in(key[255:128]), .busy(b4),
        .rk_valid(v4), .rk_ready(rk_ready), .rk_data(d4), .rk_index(i4),
        .rk_last(l4), .done(dn4));
    aes_key_expander #(.NK(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(st6), .key_in(key[255:64]), .busy(b6),
        .rk_valid(v6), .rk_ready(rk_ready), .rk_data(d6), .rk_index(i6),
        .rk_last(l6), .done(dn6));
    aes_key_expander #(.NK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .key_in(key), .busy(b8),
        .rk_valid(v8), .rk_ready(rk_ready), .rk_data(d8), .rk_index(i8),
        .rk_last(l8), .done(dn8));

    always_comb begin
        m_busy = b4; m_valid = v4; m_last = l4; m_done = dn4; m_data = d4; m_idx = i4;
        if (sel == 1) begin
            m_busy = b6; m_valid = v6; m_last = l6; m_done = dn6; m_data = d6; m_idx = i6;
        end else if (sel == 2) begin
            m_busy = b8; m_valid = v8; m_last = l8; m_done = dn8; m_data = d8; m_idx = i8;
        end
    end

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        rk_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input int idx, input logic last, input logic chk);
        sb_q.push_back('{data: d, idx: 4'(idx), last: last, chk: chk});
    endtask

    task automatic push_128();
        for (int r = 0; r < 11; r++) push(K128[r], r, r == 10, 1'b1);
    endtask

    task automatic monitor();
        exp_t         e;
        logic         held;
        logic [127:0] hd;
        held = 1'b0;
        hd   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && m_valid) check("stall_hold", m_data, hd);
                held = m_valid && !rk_ready;
                hd   = m_data;
                if (m_valid && rk_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_key: got idx=%0d data=%h, required no key", m_idx, m_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rk_index", 128'(m_idx), 128'(e.idx));
                        check("rk_last", 128'(m_last), 128'(e.last));
                        if (e.chk) check("rk_data", m_data, e.data);
                    end
                end
                if (m_done) done_cnt++;
            end
        end
    endtask

    // what: 0 = last key valid, 1 = done, 2 = any key valid
    task automatic wait_ev(input int what, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if ((what == 0 && m_valid && m_last) || (what == 1 && m_done) ||
                (what == 2 && m_valid)) begin
                at = edge_cnt;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [255:0] k, output int acc);
        @(posedge clk); #1;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc   = edge_cnt;
    endtask

    task automatic run_full(input logic [255:0] k, input int nr, input int dn_exp);
        int acc, at;
        do_start(k, acc);
        check("busy_after_start", 128'(m_busy), 128'(1));
        wait_ev(0, 200, at);
        check("last_latency", 128'(at - acc), 128'(4 * nr + 4));
        wait_ev(1, 10, at);
        check("done_latency", 128'(at - acc), 128'(4 * nr + 5));
        check("busy_at_done", 128'(m_busy), 128'(0));
        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        check("done_count", 128'(done_cnt), 128'(dn_exp));
    endtask

    initial begin
        int acc, acc2, at;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_ctrl", 128'({m_busy, m_valid, m_last, m_done, m_idx}), 128'(0));
            check("reset_data", m_data, 128'(0));
        end
        sel = 0;
        rst = 1'b0;

        // AES-128, consumer always ready
        push_128();
        run_full(KEY_A, 10, 1);

        // AES-192
        sel = 1;
        push(128'h8e73b0f7da0e6452c810f32b809079e5, 0, 1'b0, 1'b1);
        for (int r = 1; r < 12; r++) push('0, r, 1'b0, 1'b0);
        push(128'he98ba06f448c773c8ecc720401002202, 12, 1'b1, 1'b1);
        run_full(KEY_192, 12, 2);

        // AES-256
        sel = 2;
        push(128'h603deb1015ca71be2b73aef0857d7781, 0, 1'b0, 1'b1);
        push(128'h1f352c073b6108d72d9810a30914dff4, 1, 1'b0, 1'b1);
        for (int r = 2; r < 14; r++) push('0, r, 1'b0, 1'b0);
        push(128'hfe4890d1e6188d0b046df344706c631e, 14, 1'b1, 1'b1);
        run_full(KEY_256, 14, 3);

        // AES-128 under random backpressure
        sel = 0;
        rnd_mode = 1'b1;
        push_128();
        do_start(KEY_A, acc);
        wait_ev(1, 1500, at);
        check("bp_done_seen", 128'(at >= 0), 128'(1));
        rnd_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_sb_drained", 128'(sb_q.size()), 128'(0));
        check("bp_done_count", 128'(done_cnt), 128'(4));

        // Restart while busy is ignored; reset mid-run discards everything
        for (int r = 0; r < 4; r++) push(K128[r], r, 1'b0, 1'b1);
        do_start(KEY_A, acc);
        repeat (9) @(posedge clk);
        #1;
        key   = KEY_B;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ctrl", 128'({m_busy, m_valid, m_last, m_done, m_idx}), 128'(0));
        check("midrst_data", m_data, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_idle", 128'({m_busy, m_valid}), 128'(0));
        check("midrst_sb_drained", 128'(sb_q.size()), 128'(0));
        check("midrst_no_done", 128'(done_cnt), 128'(4));

        // New start accepted in the same cycle as done
        push_128();
        do_start(KEY_A, acc);
        wait_ev(1, 100, at);
        check("b2b_done_latency", 128'(at - acc), 128'(45));
        push_128();
        key   = KEY_A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc2  = edge_cnt;
        check("b2b_busy", 128'(m_busy), 128'(1));
        wait_ev(2, 20, at);
        check("b2b_first_latency", 128'(at - acc2), 128'(4));
        wait_ev(1, 100, at);
        check("b2b_done2_latency", 128'(at - acc2), 128'(45));
        repeat (3) @(negedge clk);
        check("b2b_sb_drained", 128'(sb_q.size()), 128'(0));
        check("b2b_done_count", 128'(done_cnt), 128'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative, word-serial AES key-expansion engine. Replaces the fixed per-round combinational key-schedule stages.
- Parametrised for AES-128, AES-192 and AES-256 through NK.
- Produces one 32-bit schedule word per cycle from a loaded cipher key.
- Streams the NR+1 128-bit round keys to the cipher datapath over a valid/ready handshake, with backpressure.

Parameters:
- NK, 4, key length in 32-bit words. Legal values: 4, 6, 8. Any other value fails elaboration.
- NR, NK+6, number of rounds. Derived; must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin expansion of key_in. Sampled only when busy=0.
- key_in  in  32*NK  cipher key. key_in[32*NK-1 -: 32] is w[0].
- busy  out  1  high from accepted start until the last round key is accepted.
- rk_valid  out  1  rk_data holds a complete round key.
- rk_ready  in  1  consumer accepts rk_data when rk_valid and rk_ready are both high.
- rk_data  out  128  round key. [127:96] = w[4r], [31:0] = w[4r+3].
- rk_index  out  4  round number r of rk_data, 0..NR.
- rk_last  out  1  high with rk_valid when rk_index == NR.
- done  out  1  one-cycle pulse in the cycle after the last round key is accepted.

Behaviour:
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, done=0. Internally: word counter i=0, assembly count=0, rcon=8'h01, FSM in IDLE.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE -> GEN on start. key_in is captured into an NK-word window, i=0, rcon=01, busy=1.
  - GEN -> DRAIN when word 4*(NR+1)-1 has been produced (words 43/51/59).
  - DRAIN -> IDLE when the final round key handshake completes. done pulses the next cycle; busy falls in the same cycle as that handshake.
- Word generation: one word per GEN cycle unless stalled.
  - i < NK: word = captured key word i.
  - otherwise: word = w[i-NK] ^ t, with t chosen as follows:
    - i mod NK == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. rcon then advances by xtime (x2 mod 0x11B).
    - NK == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
    - else: t = w[i-1].
  - The window shifts by one word per produced word.
- Assembly: produced words fill a 4-word buffer in order.
  - On the 4th word, the buffer transfers to the rk_data output register. rk_valid goes to 1 and rk_index is set to the round number.
- Output register: holds its value until the handshake completes.
  - An accept and a new transfer in the same cycle are legal; rk_valid stays 1 with the new data.
- Stall: no word is produced in a cycle where the buffer holds 3 words, rk_valid=1 and rk_ready=0. Word order and values never change under backpressure.
- Latency with rk_ready held 1:
  - start is accepted at edge 0.
  - Word j is registered at edge j+1.
  - Round key r is visible (rk_valid) after edge 4r+4.
  - Last key is visible after edge 4NR+4: 44 / 52 / 60 cycles.
- start while busy=1: ignored; no effect on key, counters or outputs.
- start in the same cycle as done: accepted.
- rst mid-operation: all state and outputs return to reset values at that edge. The partial schedule is discarded and no done pulse is issued.
- key_in is only sampled on the start-accept edge. Later changes have no effect.

Decomposition:
- Shared package aes_pkg holds:
  - typedef word_t (logic [31:0]);
  - RCON_INIT = 8'h01;
  - xtime function;
  - FSM enum {IDLE, GEN, DRAIN};
  - function nr_of(nk) returning nk+6.
- Sub-module aes_sub_word: 32-bit SubWord built from four instances of the combinational byte S-box. It is shared with the cipher datapath. One instance sits in this block.

Test Plan:
- AES-128 (NK=4), key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_index 1 = a0fafe1788542cb123a339392a6c7605; rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, valid at cycle 44; done at cycle 45.
- AES-192 (NK=6), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_index 12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
- AES-256 (NK=8), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_index 14 = fe4890d1e6188d0b046df344706c631e; checks the i mod 8 == 4 SubWord path.
- AES-128 with rk_ready driven by a random 30% duty pattern -> identical 11 keys in order; rk_data stable while rk_valid=1 and rk_ready=0; no key lost or duplicated.
- start pulsed again at cycle 10 with a different key, then rst asserted at cycle 20 -> second start ignored; all outputs 0 after the reset edge; no done pulse.
- A fresh start in the same cycle as done -> new expansion proceeds; rk_index 0 of the new key appears 4 cycles after acceptance.
